// File: rtl/cfg_load_ctrl.sv
// Purpose: serial configuration loader; synchronises SpiCk/SpiDat/SpiCs, frames and
//          parity-checks one CFG_W-bit word (MSB first, plus one even-parity bit) and commits it.
// Latency: CfgWe_o/Cfg_o update 3 Clk_i edges after the first edge that samples SpiCs_ani high.
// Backpressure: none; the serial master must respect the minimum SpiCk phase and data setup/hold.
//
// Ports:
//   Clk_i, Rst_ni          system clock, async-assert active-low reset
//   SpiCk_ai, SpiDat_ai    asynchronous serial clock (rising-edge sampled) and data
//   SpiCs_ani              asynchronous active-low frame select
//   ErrClr_i               synchronous clear of the sticky error flag
//   Cfg_o, CfgWe_o         committed word and its one-cycle write strobe
//   FsmHold_o              hold request while loading or before the first valid word
//   CfgValid_o, Err_o      a word has been committed since reset; sticky frame error
module cfg_load_ctrl #(
    parameter int CFG_W   = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic             Clk_i,
    input  logic             Rst_ni,
    input  logic             SpiCk_ai,
    input  logic             SpiDat_ai,
    input  logic             SpiCs_ani,
    input  logic             ErrClr_i,
    output logic [CFG_W-1:0] Cfg_o,
    output logic             CfgWe_o,
    output logic             FsmHold_o,
    output logic             CfgValid_o,
    output logic             Err_o
);

    localparam int BC_W = $clog2(CFG_W + 3);
    localparam int IC_W = $clog2(TIMEOUT + 1);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(CFG_W + 1);  // data bits + parity bit
    localparam logic [BC_W-1:0] BC_MAX  = BC_W'(CFG_W + 2);  // saturated: overflow marker
    localparam logic [IC_W-1:0] IC_LAST = IC_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, SHIFT, CHECK, COMMIT, ERROR} state_t;

    state_t            state_q, state_nxt;
    // Synchroniser chain, bit order {cs, dat, ck}
    logic [2:0]        meta_q, sync_q, hist_q;
    logic [CFG_W:0]    shift_q, shift_nxt;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_nxt;
    logic [IC_W-1:0]   idle_cnt_q, idle_cnt_nxt;
    logic              ck_rise, cs_rise, cs_fall, cs_s, dat_s;
    logic              commit, err_set, valid_nxt;

    assign ck_rise = sync_q[0] & ~hist_q[0];
    assign cs_rise = sync_q[2] & ~hist_q[2];
    assign cs_fall = ~sync_q[2] & hist_q[2];
    assign cs_s    = sync_q[2];
    // Data history is aligned with the last low sample of SpiCk, i.e. the value
    // present just before the rising edge; the setup/hold window covers it.
    assign dat_s   = hist_q[1];

    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        shift_nxt    = shift_q;
        bit_cnt_nxt  = bit_cnt_q;
        idle_cnt_nxt = idle_cnt_q;
        commit       = 1'b0;
        err_set      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    bit_cnt_nxt  = '0;
                    idle_cnt_nxt = '0;
                    state_nxt    = SHIFT;
                end
            end
            SHIFT: begin
                // CS rise wins over a coincident SpiCk rise: that bit is dropped.
                if (cs_rise) begin
                    state_nxt = CHECK;
                end else if (ck_rise && !cs_s) begin
                    shift_nxt    = {shift_q[CFG_W-1:0], dat_s};
                    idle_cnt_nxt = '0;
                    if (bit_cnt_q != BC_MAX) begin
                        bit_cnt_nxt = bit_cnt_q + 1'b1;
                    end
                end else if (idle_cnt_q == IC_LAST) begin
                    // Counter reaches TIMEOUT on the same edge the frame aborts.
                    idle_cnt_nxt = idle_cnt_q + 1'b1;
                    err_set      = 1'b1;
                    state_nxt    = ERROR;
                end else begin
                    idle_cnt_nxt = idle_cnt_q + 1'b1;
                end
            end
            CHECK: begin
                if ((bit_cnt_q == BC_FULL) && !(^shift_q)) begin
                    commit    = 1'b1;
                    state_nxt = COMMIT;
                end else begin
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            COMMIT: begin
                state_nxt = IDLE;
            end
            ERROR: begin
                if (cs_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign valid_nxt = CfgValid_o | commit;

    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            meta_q     <= '0;
            sync_q     <= '0;
            hist_q     <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            idle_cnt_q <= '0;
            Cfg_o      <= '0;
            CfgWe_o    <= 1'b0;
            FsmHold_o  <= 1'b1;
            CfgValid_o <= 1'b0;
            Err_o      <= 1'b0;
        end else begin
            meta_q     <= {SpiCs_ani, SpiDat_ai, SpiCk_ai};
            sync_q     <= meta_q;
            hist_q     <= sync_q;
            shift_q    <= shift_nxt;
            bit_cnt_q  <= bit_cnt_nxt;
            idle_cnt_q <= idle_cnt_nxt;
            CfgWe_o    <= commit;
            if (commit) begin
                Cfg_o <= shift_q[CFG_W:1];
            end
            CfgValid_o <= valid_nxt;
            FsmHold_o  <= (state_nxt != IDLE) | ~valid_nxt;
            // Set has priority over a same-cycle clear.
            Err_o      <= err_set | (Err_o & ~ErrClr_i);
        end
    end

endmodule

// File: tb/tb_cfg_load_ctrl.sv
module tb_cfg_load_ctrl;

    localparam int CFG_W   = 8;
    localparam int TIMEOUT = 16;

    logic             Clk_i = 1'b0;
    logic             Rst_ni;
    logic             SpiCk_ai;
    logic             SpiDat_ai;
    logic             SpiCs_ani;
    logic             ErrClr_i;
    logic [CFG_W-1:0] Cfg_o;
    logic             CfgWe_o;
    logic             FsmHold_o;
    logic             CfgValid_o;
    logic             Err_o;

    int n_chk  = 0;
    int n_err  = 0;
    int we_cnt = 0;
    int w0;

    cfg_load_ctrl #(.CFG_W(CFG_W), .TIMEOUT(TIMEOUT)) dut (
        .Clk_i      (Clk_i),
        .Rst_ni     (Rst_ni),
        .SpiCk_ai   (SpiCk_ai),
        .SpiDat_ai  (SpiDat_ai),
        .SpiCs_ani  (SpiCs_ani),
        .ErrClr_i   (ErrClr_i),
        .Cfg_o      (Cfg_o),
        .CfgWe_o    (CfgWe_o),
        .FsmHold_o  (FsmHold_o),
        .CfgValid_o (CfgValid_o),
        .Err_o      (Err_o)
    );

    always #5 Clk_i = ~Clk_i;

    // Count commit strobes shortly after each active edge.
    always @(posedge Clk_i) begin
        #2;
        if (CfgWe_o === 1'b1) we_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk_i);
    endtask

    task automatic send_bit(input logic b);
        SpiDat_ai = b;
        tick(4);
        SpiCk_ai = 1'b1;
        tick(4);
        SpiCk_ai = 1'b0;
    endtask

    task automatic frame_open(input logic [15:0] bits, input int n);
        SpiCs_ani = 1'b0;
        tick(4);
        for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
        tick(4);
    endtask

    task automatic frame_close();
        SpiCs_ani = 1'b1;
        tick(10);
    endtask

    task automatic frame(input logic [15:0] bits, input int n);
        frame_open(bits, n);
        frame_close();
    endtask

    // Final SpiCk rise driven together with the CS rise.
    task automatic coincident_close();
        SpiDat_ai = 1'b0;
        tick(4);
        SpiCk_ai  = 1'b1;
        SpiCs_ani = 1'b1;
        tick(4);
        SpiCk_ai  = 1'b0;
        tick(8);
    endtask

    task automatic clr_err();
        ErrClr_i = 1'b1;
        tick(1);
        ErrClr_i = 1'b0;
        tick(1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Rst_ni    = 1'b0;
        SpiCk_ai  = 1'b0;
        SpiDat_ai = 1'b0;
        SpiCs_ani = 1'b1;
        ErrClr_i  = 1'b0;
        tick(3);
        chk("rst_cfg",   32'(Cfg_o),      32'h0);
        chk("rst_we",    32'(CfgWe_o),    32'h0);
        chk("rst_hold",  32'(FsmHold_o),  32'h1);
        chk("rst_valid", 32'(CfgValid_o), 32'h0);
        chk("rst_err",   32'(Err_o),      32'h0);
        Rst_ni = 1'b1;
        tick(5);

        // 1: 0xA5 + parity 0, latency from first edge seeing CS high
        w0 = we_cnt;
        frame_open(16'h014A, 9);
        SpiCs_ani = 1'b1;
        repeat (3) @(posedge Clk_i);       // k, k+1, k+2
        @(negedge Clk_i);
        chk("t1_we_k2", 32'(CfgWe_o), 32'h0);
        @(posedge Clk_i);                  // k+3
        @(negedge Clk_i);
        chk("t1_we_k3",    32'(CfgWe_o),    32'h1);
        chk("t1_cfg_k3",   32'(Cfg_o),      32'hA5);
        chk("t1_valid_k3", 32'(CfgValid_o), 32'h1);
        chk("t1_hold_k3",  32'(FsmHold_o),  32'h1);
        @(posedge Clk_i);                  // k+4
        @(negedge Clk_i);
        chk("t1_we_k4",   32'(CfgWe_o),   32'h0);
        chk("t1_hold_k4", 32'(FsmHold_o), 32'h0);
        chk("t1_err",     32'(Err_o),     32'h0);
        tick(5);
        chk("t1_we_pulses", 32'(we_cnt - w0), 32'd1);

        // 2: 0x3C + parity 1 (odd) -> rejected, old word kept
        w0 = we_cnt;
        frame_open(16'h0079, 9);
        chk("t2_hold_busy", 32'(FsmHold_o), 32'h1);
        frame_close();
        chk("t2_err",   32'(Err_o),          32'h1);
        chk("t2_cfg",   32'(Cfg_o),          32'hA5);
        chk("t2_hold",  32'(FsmHold_o),      32'h0);
        chk("t2_no_we", 32'(we_cnt - w0),    32'd0);
        clr_err();
        chk("t2_errclr", 32'(Err_o), 32'h0);

        // 3: short, long, and zero-bit frames
        w0 = we_cnt;
        frame(16'h0055, 7);
        chk("t3_short_err", 32'(Err_o), 32'h1);
        clr_err();
        frame(16'h0294, 10);
        chk("t3_long_err", 32'(Err_o), 32'h1);
        clr_err();
        SpiCs_ani = 1'b0;
        tick(4);
        frame_close();
        chk("t3_zero_err", 32'(Err_o), 32'h1);
        chk("t3_no_we",    32'(we_cnt - w0), 32'd0);
        chk("t3_cfg",      32'(Cfg_o), 32'hA5);
        clr_err();

        // 4: SpiCk stalls after 3 bits -> timeout abort
        w0 = we_cnt;
        SpiCs_ani = 1'b0;
        tick(4);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        tick(6);                           // ~10 cycles after last rise
        chk("t4_err_early", 32'(Err_o),     32'h0);
        chk("t4_hold_busy", 32'(FsmHold_o), 32'h1);
        tick(12);                          // ~22 cycles after last rise
        chk("t4_err_timeout", 32'(Err_o), 32'h1);
        send_bit(1'b1);
        send_bit(1'b0);
        tick(4);
        frame_close();
        chk("t4_no_we", 32'(we_cnt - w0), 32'd0);
        chk("t4_cfg",   32'(Cfg_o),       32'hA5);
        chk("t4_hold",  32'(FsmHold_o),   32'h0);
        clr_err();
        w0 = we_cnt;
        frame(16'h0186, 9);                // 0xC3 + parity 0
        chk("t4_cfg_new", 32'(Cfg_o),       32'hC3);
        chk("t4_we_new",  32'(we_cnt - w0), 32'd1);
        chk("t4_err_new", 32'(Err_o),       32'h0);

        // 6: SpiCk rise coinciding with CS rise is not counted
        w0 = we_cnt;
        frame_open(16'h00B4, 9);           // 0x5A + parity 0, extra edge would overflow
        coincident_close();
        chk("t6a_cfg", 32'(Cfg_o),       32'h5A);
        chk("t6a_we",  32'(we_cnt - w0), 32'd1);
        chk("t6a_err", 32'(Err_o),       32'h0);
        w0 = we_cnt;
        frame_open(16'h0066, 8);           // would complete as 0x66+0 if edge counted
        coincident_close();
        chk("t6b_err", 32'(Err_o),       32'h1);
        chk("t6b_cfg", 32'(Cfg_o),       32'h5A);
        chk("t6b_we",  32'(we_cnt - w0), 32'd0);
        clr_err();

        // 5: reset during bit 5 of a frame
        w0 = we_cnt;
        SpiCs_ani = 1'b0;
        tick(4);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        SpiDat_ai = 1'b1;
        tick(2);
        Rst_ni = 1'b0;
        #1;
        chk("t5_rst_cfg",   32'(Cfg_o),      32'h0);
        chk("t5_rst_we",    32'(CfgWe_o),    32'h0);
        chk("t5_rst_hold",  32'(FsmHold_o),  32'h1);
        chk("t5_rst_valid", 32'(CfgValid_o), 32'h0);
        chk("t5_rst_err",   32'(Err_o),      32'h0);
        tick(2);
        Rst_ni = 1'b1;
        tick(2);
        SpiCk_ai = 1'b1;
        tick(4);
        SpiCk_ai = 1'b0;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        tick(4);
        frame_close();
        chk("t5_no_we", 32'(we_cnt - w0), 32'd0);
        chk("t5_valid", 32'(CfgValid_o),  32'h0);
        chk("t5_hold",  32'(FsmHold_o),   32'h1);
        chk("t5_cfg",   32'(Cfg_o),       32'h0);
        w0 = we_cnt;
        frame(16'h0132, 9);                // 0x99 + parity 0
        chk("t5_cfg_new",   32'(Cfg_o),       32'h99);
        chk("t5_valid_new", 32'(CfgValid_o),  32'h1);
        chk("t5_hold_new",  32'(FsmHold_o),   32'h0);
        chk("t5_we_new",    32'(we_cnt - w0), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
